// File: rtl/rgb_mixer_multi_if.sv
// rgb_mixer_multi_if: encoder pins, host preload port and PWM/duty outputs of the mixer
interface rgb_mixer_multi_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       enc_a;
  logic [CHANNELS-1:0]       enc_b;
  logic [CHANNELS-1:0]       wrap_en;
  logic                      load_en;
  logic [2:0]                load_ch;
  logic [WIDTH-1:0]          load_val;
  logic [CHANNELS*WIDTH-1:0] value_o;
  logic [CHANNELS-1:0]       pwm_o;
  logic                      period_start_o;
  modport master (
    output enc_a, enc_b, wrap_en, load_en, load_ch, load_val,
    input  value_o, pwm_o, period_start_o
  );
  modport slave (
    input  enc_a, enc_b, wrap_en, load_en, load_ch, load_val,
    output value_o, pwm_o, period_start_o
  );
endinterface

// File: rtl/rgb_mixer_multi.sv
// rgb_mixer_multi: per-channel debounced quadrature encoders driving duty registers and period-aligned PWM
module rgb_mixer_multi #(
  parameter int CHANNELS        = 3,
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic               clk,
  input logic               reset_n,
  rgb_mixer_multi_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [CHANNELS-1:0] a_m, a_s, b_m, b_s, a_db, b_db, a_db_d, up, dn, ld;
  logic [CW-1:0] cnt_a [CHANNELS];
  logic [CW-1:0] cnt_b [CHANNELS];
  logic [WIDTH-1:0] value [CHANNELS];
  logic [WIDTH-1:0] sh [CHANNELS];
  logic [WIDTH-1:0] sh_next [CHANNELS];
  logic [WIDTH-1:0] pc, pc_next;
  always_comb begin
    pc_next = pc + 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      up[k] = a_db[k] & ~a_db_d[k] & ~b_db[k];
      dn[k] = a_db[k] & ~a_db_d[k] & b_db[k];
      ld[k] = bus.load_en && (bus.load_ch == 3'(k));
      sh_next[k] = (pc == MAX) ? value[k] : sh[k];
      bus.value_o[k*WIDTH +: WIDTH] = value[k];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_m    <= '0;
      a_s    <= '0;
      b_m    <= '0;
      b_s    <= '0;
      a_db   <= '0;
      b_db   <= '0;
      a_db_d <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_a[k] <= '0;
        cnt_b[k] <= '0;
        value[k] <= '0;
      end
    end else begin
      a_m    <= bus.enc_a;
      a_s    <= a_m;
      b_m    <= bus.enc_b;
      b_s    <= b_m;
      a_db_d <= a_db;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_a[k] <= (a_s[k] == a_db[k] || cnt_a[k] == LAST) ? '0 : cnt_a[k] + 1'b1;
        cnt_b[k] <= (b_s[k] == b_db[k] || cnt_b[k] == LAST) ? '0 : cnt_b[k] + 1'b1;
        if (a_s[k] != a_db[k] && cnt_a[k] == LAST) a_db[k] <= a_s[k];
        if (b_s[k] != b_db[k] && cnt_b[k] == LAST) b_db[k] <= b_s[k];
        // a host preload wins over an encoder step landing in the same cycle
        if (ld[k]) value[k] <= bus.load_val;
        else if (up[k]) value[k] <= (value[k] == MAX) ? (bus.wrap_en[k] ? '0 : MAX) : value[k] + 1'b1;
        else if (dn[k]) value[k] <= (value[k] == '0) ? (bus.wrap_en[k] ? MAX : '0) : value[k] - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc                 <= '0;
      bus.pwm_o          <= '0;
      bus.period_start_o <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) sh[k] <= '0;
    end else begin
      pc                 <= pc_next;
      bus.period_start_o <= (pc_next == '0);
      for (int k = 0; k < CHANNELS; k++) begin
        sh[k]        <= sh_next[k];
        bus.pwm_o[k] <= (pc_next < sh_next[k]);
      end
    end
  end
endmodule

// File: tb/tb_rgb_mixer_multi.sv
// tb_rgb_mixer_multi: directed stimulus with a value_o scoreboard and PWM duty measurements
module tb_rgb_mixer_multi;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  rgb_mixer_multi_if #(.CHANNELS(3), .WIDTH(8)) bus ();
  rgb_mixer_multi #(.CHANNELS(3), .WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  typedef struct {
    logic [23:0] v;
    int          c;
    string       n;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [23:0] prev = '0;
  always @(posedge clk) cyc++;
  // every change of value_o must match the next expected value at the expected edge
  always @(negedge clk) begin
    if (mon_en && bus.value_o !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: value_o got %h expected %h (cycle %0d)", bus.value_o, prev, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.value_o !== e.v || cyc != e.c) begin
          errors++;
          $display("FAIL %s: value_o got %h at cycle %0d expected %h at cycle %0d", e.n, bus.value_o, cyc, e.v, e.c);
        end
      end
      prev = bus.value_o;
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic expect_val(input string n, input logic [23:0] v, input int lat);
    sb.push_back('{v, cyc + lat, n});
  endtask
  task automatic load(input int ch, input logic [7:0] v, input bit exp, input logic [23:0] ev, input string n);
    bus.load_en = 1'b1;
    bus.load_ch = 3'(ch);
    bus.load_val = v;
    if (exp) expect_val(n, ev, 1);
    @(posedge clk);
    #1 bus.load_en = 1'b0;
  endtask
  task automatic step(input int ch, input bit d, input int len, input bit exp, input logic [23:0] ev,
                      input string n, input bit coll);
    bus.enc_b[ch] = d;
    repeat (10) @(posedge clk);
    #1 bus.enc_a[ch] = 1'b1;
    if (exp) expect_val(n, ev, 7);
    repeat (len) @(posedge clk);
    #1;
    if (coll) begin
      bus.load_en = 1'b1;
      bus.load_ch = 3'(ch);
      bus.load_val = 8'h40;
    end
    bus.enc_a[ch] = 1'b0;
    @(posedge clk);
    #1 bus.load_en = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask
  task automatic measure(output int hi, input int mid, input logic [7:0] mv, input logic [23:0] mev);
    int n = 0;
    hi = 0;
    while (!bus.period_start_o && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("period_start_seen", 32'(n < 600), 32'd1);
    for (int i = 0; i < 256; i++) begin
      hi += int'(bus.pwm_o[0]);
      if (i == mid) begin
        bus.load_en = 1'b1;
        bus.load_ch = 3'd0;
        bus.load_val = mv;
        expect_val("mid_period_load", mev, 1);
      end
      if (i == mid + 1) bus.load_en = 1'b0;
      @(negedge clk);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int hi;
    int n;
    bus.enc_a = '0;
    bus.enc_b = '0;
    bus.wrap_en = '0;
    bus.load_en = 1'b0;
    bus.load_ch = '0;
    bus.load_val = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_value", 32'(bus.value_o), 32'h0);
    chk("reset_pwm", 32'(bus.pwm_o), 32'h0);
    chk("reset_pstart", 32'(bus.period_start_o), 32'h0);
    mon_en = 1'b1;
    load(0, 8'h11, 1'b1, 24'h000011, "pre_reset_load");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    expect_val("reset_clear", 24'h0, 1);
    for (int i = 0; i < 3; i++) begin
      bus.enc_a = ~bus.enc_a;
      bus.enc_b = bus.enc_b ^ 3'b101;
      @(posedge clk);
      #1;
    end
    chk("midrun_reset_value", 32'(bus.value_o), 32'h0);
    chk("midrun_reset_pwm", 32'(bus.pwm_o), 32'h0);
    chk("midrun_reset_pstart", 32'(bus.period_start_o), 32'h0);
    bus.enc_a = '0;
    bus.enc_b = '0;
    reset_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.period_start_o && n < 400);
    chk("pc_restart_period", 32'(n), 32'd256);
    for (int v = 1; v <= 5; v++) step(1, 1'b0, 6, 1'b1, 24'(v << 8), "ch1_up", 1'b0);
    step(1, 1'b1, 6, 1'b1, 24'h000400, "ch1_down", 1'b0);
    step(1, 1'b1, 6, 1'b1, 24'h000300, "ch1_down", 1'b0);
    step(0, 1'b0, 3, 1'b0, 24'h0, "glitch", 1'b0);
    chk("glitch_nochange", 32'(bus.value_o), 32'h000300);
    step(0, 1'b0, 6, 1'b1, 24'h000301, "debounced_up", 1'b0);
    load(2, 8'hFF, 1'b1, 24'hFF0301, "ch2_load_ff");
    step(2, 1'b0, 6, 1'b0, 24'h0, "sat_up", 1'b0);
    chk("sat_up_hold", 32'(bus.value_o), 32'hFF0301);
    bus.wrap_en[2] = 1'b1;
    step(2, 1'b0, 6, 1'b1, 24'h000301, "wrap_up", 1'b0);
    step(2, 1'b1, 6, 1'b1, 24'hFF0301, "wrap_down", 1'b0);
    load(2, 8'h00, 1'b1, 24'h000301, "ch2_load_0");
    bus.wrap_en[2] = 1'b0;
    step(2, 1'b1, 6, 1'b0, 24'h0, "sat_down", 1'b0);
    chk("sat_down_hold", 32'(bus.value_o), 32'h000301);
    step(0, 1'b0, 6, 1'b1, 24'h000340, "load_collision", 1'b1);
    load(5, 8'h77, 1'b0, 24'h0, "bad_ch");
    repeat (3) @(posedge clk);
    #1 chk("bad_ch_ignored", 32'(bus.value_o), 32'h000340);
    @(negedge clk);
    measure(hi, -1, 8'h0, 24'h0);
    measure(hi, 100, 8'h80, 24'h000380);
    chk("pwm_old_duty_64", 32'(hi), 32'd64);
    measure(hi, -1, 8'h0, 24'h0);
    chk("pwm_new_duty_128", 32'(hi), 32'd128);
    load(0, 8'h00, 1'b1, 24'h000300, "duty_zero");
    @(negedge clk);
    measure(hi, -1, 8'h0, 24'h0);
    measure(hi, -1, 8'h0, 24'h0);
    chk("pwm_zero", 32'(hi), 32'd0);
    load(0, 8'hFF, 1'b1, 24'h0003FF, "duty_max");
    @(negedge clk);
    measure(hi, -1, 8'h0, 24'h0);
    measure(hi, -1, 8'h0, 24'h0);
    chk("pwm_max_255", 32'(hi), 32'd255);
    repeat (4) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_mixer_multi.md
# rgb_mixer_multi

Parametrised successor to the three-channel encoder/PWM mixer: CHANNELS independent rotary-encoder inputs, each synchronised, debounced and quadrature-decoded into a WIDTH-bit duty register that drives one PWM output. New over the previous generation: per-channel wrap/saturate mode, a host preload port, and period-aligned (glitch-free) duty updates. It sits inside the user project wrapper; encoder pins come from io_in and PWM outputs go to io_out.

## Interface
- CHANNELS, 3, number of encoder/PWM channel pairs (1..8)
- WIDTH, 8, duty register and PWM counter width (4..16)
- DEBOUNCE_CYCLES, 16, consecutive clocks a synchronised input must differ from its debounced value before it is accepted (>=1)

- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enc_a  in  CHANNELS  encoder A pins, asynchronous
- enc_b  in  CHANNELS  encoder B pins, asynchronous
- wrap_en  in  CHANNELS  per channel: 1 = value wraps at limits, 0 = saturates
- load_en  in  1  single-cycle preload strobe
- load_ch  in  3  channel index for preload; index >= CHANNELS ignored
- load_val  in  WIDTH  preload value
- value_o  out  CHANNELS*WIDTH  packed duty registers, channel i at [i*WIDTH +: WIDTH]
- pwm_o  out  CHANNELS  registered PWM outputs
- period_start_o  out  1  one-cycle pulse when the PWM counter is 0

## Operation
- Sync: each enc_a/enc_b bit passes through two flops (a_s, b_s).
- Debounce (per bit): counter cnt resets to 0 whenever a_s == a_db; otherwise increments; on the edge where a_s != a_db and cnt == DEBOUNCE_CYCLES-1, a_db <= a_s and cnt <= 0. Identical logic for b.
- Decode: event when a_db == 1 and a_db_d == 0 (a_db_d is a_db delayed one clock). b_db == 0 -> up; b_db == 1 -> down. One step per rising edge of debounced A; falling edges and B edges produce no step.
- Count update, per channel:
  - up at 2^WIDTH-1: wrap_en ? 0 : hold; else +1.
  - down at 0: wrap_en ? 2^WIDTH-1 : hold; else -1.
- Preload: load_en with valid load_ch writes load_val to that channel's value next edge; preload overrides an encoder event on the same channel in the same cycle (event discarded). Other channels unaffected.
- PWM: one shared free-running WIDTH-bit counter pc, 0..2^WIDTH-1, wraps to 0. Per channel shadow duty sh[i] loaded from value[i] on the edge where pc wraps to 0 (pc == 2^WIDTH-1). pwm_o[i] <= (pc_next < sh_next[i]), i.e. registered compare aligned so that each period begins with pwm_o high for exactly sh cycles.
- Duty 0 -> pwm_o constant low; duty 2^WIDTH-1 -> high 2^WIDTH-1 of 2^WIDTH cycles.

## Timing
- Reset (reset_n low at an edge): all sync/debounce flops, a_db, b_db, cnt, value, sh, pc cleared to 0; pwm_o = 0, value_o = 0, period_start_o = 0. Reset mid-period or mid-debounce discards all in-flight state; first period after release starts with pc = 0.
- Encoder latency: A rising at pin before edge 0, held stable, b stable -> a_db rises at edge DEBOUNCE_CYCLES+2, value_o updates at edge DEBOUNCE_CYCLES+3.
- Glitch shorter than DEBOUNCE_CYCLES clocks (after sync) -> no event.
- Preload latency: value_o updates one edge after load_en sampled high.
- Duty change reaches pwm_o only from the next period start; in-progress period completes with old duty.
- period_start_o high for the one cycle in which pc == 0; period = 2^WIDTH clocks.

## Test plan
- Reset: hold reset_n low 3 clocks with encoders toggling -> value_o = 0, pwm_o = 0, pc restarts at 0 after release.
- Up/down (WIDTH=8, DEBOUNCE_CYCLES=4): ch1 five A rising edges with B low, then two with B high -> value ch1 = 3, appearing at edge 7 after each A edge; ch0/ch2 stay 0.
- Debounce: 3-cycle A pulse on ch0 -> no change; 6-cycle pulse -> +1.
- Limits: ch2 preload 255, one up step with wrap_en=0 -> 255; wrap_en=1 -> 0; one down from 0 with wrap_en=1 -> 255.
- Preload collision: load_en ch0 val 0x40 in same cycle as ch0 up event -> value ch0 = 0x40; load_ch=5 -> no change.
- PWM: ch0 duty 0x40 -> pwm_o[0] high exactly 64 of 256 clocks per period from period_start_o; change duty to 0x80 mid-period -> current period still 64, next 128; duty 0 -> never high.
